// File: rtl/dendrite_arbiter.sv
// Arbiter that shares the dendrite accumulation unit between four synapse fire ports
// (round-robin) and the incoming-fire port (priority). Optional starvation guard: UCASPIAN_DEND_ARB_STARVE_GUARD_EN.

package dendrite_arbiter_pkg;
  typedef struct packed {
    logic [7:0] addr;
    logic [8:0] charge;
  } fire_t;
endpackage

module dendrite_arbiter_lane
  import dendrite_arbiter_pkg::*;
#(
  parameter int unsigned LANE  = 0,
  parameter int unsigned SEL_W = 2
) (
  input  logic [7:0]       addr,
  input  logic [7:0]       charge,
  input  logic [SEL_W-1:0] rr_ptr,
  input  logic             grant_syn,
  input  logic [SEL_W-1:0] sel,
  output fire_t            fire,
  output logic [SEL_W-1:0] rank,
  output logic             rdy
);
  // Rank is the lane's distance from the round-robin pointer; rank 0 is searched first.
  assign rank = SEL_W'(LANE) - rr_ptr;
  assign fire = '{addr: addr, charge: {charge[7], charge}};
  assign rdy  = grant_syn && (sel == SEL_W'(LANE));
endmodule

module dendrite_arbiter
  import dendrite_arbiter_pkg::*;
#(
  parameter int unsigned IN_BURST_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] syn_dend_addr,
  input  logic [31:0] syn_dend_charge,
  input  logic [3:0]  syn_dend_vld,
  output logic [3:0]  syn_dend_rdy,
  input  logic [7:0]  incoming_addr,
  input  logic [7:0]  incoming_charge,
  input  logic        incoming_vld,
  output logic        incoming_rdy,
  output logic [7:0]  dend_addr,
  output logic [8:0]  dend_charge,
  output logic        dend_vld,
  input  logic        dend_rdy,
  output logic        idle
);
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned SEL_W     = 2;

  typedef enum logic {IN_PRIO, SYN_FORCE} guard_state_e;

  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             dend_vld_q, dend_vld_d;
  fire_t            dend_q, dend_d;

  fire_t [NUM_LANES-1:0]            lane_fire;
  logic  [NUM_LANES-1:0][SEL_W-1:0] lane_rank;
  logic  [NUM_LANES-1:0]            lane_rdy;

  logic             syn_any;
  logic [SEL_W-1:0] syn_sel;
  logic [SEL_W-1:0] best_rank;
  logic             guard_force;
  logic             in_win;
  logic             can_load;
  logic             grant;
  logic             inc_grant;
  logic             syn_grant;
  fire_t            win_fire;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    dendrite_arbiter_lane #(.LANE(k), .SEL_W(SEL_W)) u_lane (
      .addr      (syn_dend_addr[8*k +: 8]),
      .charge    (syn_dend_charge[8*k +: 8]),
      .rr_ptr    (rr_ptr_q),
      .grant_syn (syn_grant),
      .sel       (syn_sel),
      .fire      (lane_fire[k]),
      .rank      (lane_rank[k]),
      .rdy       (lane_rdy[k])
    );
  end

  // First valid lane at or after rr_ptr, i.e. the valid lane with the smallest rank.
  always_comb begin
    syn_any   = 1'b0;
    syn_sel   = '0;
    best_rank = '1;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (syn_dend_vld[k] && (!syn_any || lane_rank[k] < best_rank)) begin
        syn_any   = 1'b1;
        best_rank = lane_rank[k];
        syn_sel   = SEL_W'(k);
      end
    end
  end

  assign can_load  = !dend_vld_q || dend_rdy;
  assign in_win    = incoming_vld && !guard_force;
  assign grant     = enable && can_load && (in_win || syn_any);
  assign inc_grant = grant && in_win;
  assign syn_grant = grant && !in_win;
  assign win_fire  = in_win ? fire_t'{addr: incoming_addr, charge: {1'b0, incoming_charge}}
                            : lane_fire[syn_sel];

  // Readies are forced low while reset is held so upstream never sees a lost handshake.
  assign syn_dend_rdy = lane_rdy & {NUM_LANES{reset}};
  assign incoming_rdy = inc_grant & reset;

  always_comb begin
    dend_vld_d = dend_vld_q;
    dend_d     = dend_q;
    rr_ptr_d   = rr_ptr_q;
    if (grant) begin
      dend_vld_d = 1'b1;
      dend_d     = win_fire;
    end else if (can_load) begin
      dend_vld_d = 1'b0;
    end
    if (syn_grant) rr_ptr_d = syn_sel + SEL_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dend_vld_q <= 1'b0;
      dend_q     <= '0;
      rr_ptr_q   <= '0;
    end else begin
      dend_vld_q <= dend_vld_d;
      dend_q     <= dend_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

`ifdef UCASPIAN_DEND_ARB_STARVE_GUARD_EN
  guard_state_e state_q, state_d;
  logic [3:0]   burst_cnt_q, burst_cnt_d;

  // Force only bites while a synapse is actually waiting; otherwise incoming flows this cycle.
  assign guard_force = (state_q == SYN_FORCE) && syn_any;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    if (enable) begin
      case (state_q)
        IN_PRIO: begin
          if (inc_grant && syn_any) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
            if (burst_cnt_d == 4'(IN_BURST_MAX)) state_d = SYN_FORCE;
          end else if (syn_grant || !syn_any) begin
            burst_cnt_d = '0;
          end
        end
        SYN_FORCE: begin
          if (syn_grant || !syn_any) begin
            state_d     = IN_PRIO;
            burst_cnt_d = '0;
          end
        end
        default: state_d = IN_PRIO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IN_PRIO;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  // Strict incoming priority; the guard state is permanently IN_PRIO.
  assign guard_force = 1'b0;
`endif

  assign dend_vld    = dend_vld_q;
  assign dend_addr   = dend_q.addr;
  assign dend_charge = dend_q.charge;
  assign idle        = !dend_vld_q && !incoming_vld && !(|syn_dend_vld);

endmodule

// File: tb/tb_dendrite_arbiter.sv
// Scoreboard bench for dendrite_arbiter: a spec-level model predicts each grant,
// pushes the expected fire, and a negedge monitor checks fires as they are accepted.
module tb_dendrite_arbiter;
  localparam int BMAX = 8;
`ifdef UCASPIAN_DEND_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b1;
  logic [3:0][7:0] sa, sc;
  logic [3:0] sv = '0;
  logic [3:0] syn_dend_rdy;
  logic [7:0] ia = '0, ic = '0;
  logic ivld = 1'b0;
  logic incoming_rdy;
  logic [7:0] dend_addr;
  logic [8:0] dend_charge;
  logic dend_vld;
  logic drdy = 1'b1;
  logic idle;

  always #5 clk = ~clk;

  dendrite_arbiter #(.IN_BURST_MAX(BMAX)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .syn_dend_addr(sa), .syn_dend_charge(sc), .syn_dend_vld(sv), .syn_dend_rdy(syn_dend_rdy),
    .incoming_addr(ia), .incoming_charge(ic), .incoming_vld(ivld), .incoming_rdy(incoming_rdy),
    .dend_addr(dend_addr), .dend_charge(dend_charge), .dend_vld(dend_vld), .dend_rdy(drdy),
    .idle(idle)
  );

  typedef struct { int addr; int charge; } exp_t;
  exp_t q[$];
  int checks = 0, passes = 0;
  int m_rr = 0, m_cnt = 0;
  bit m_force = 0, m_vld = 0;
  int last_who = -1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  // Spec-level reference: decide this cycle's grant from the driven inputs.
  task automatic model(output bit [3:0] er, output bit ei, output int who);
    bit any, frc, can, g;
    exp_t e;
    any = |sv;
    frc = GUARD && m_force && any;
    can = !m_vld || drdy;
    g   = enable && can;
    er = '0; ei = 0; who = -1;
    if (g && ivld && !frc) begin
      who = 4; ei = 1;
      e.addr = ia; e.charge = ic;
      q.push_back(e);
    end else if (g && any) begin
      for (int i = 0; i < 4; i++) begin
        int k;
        k = (m_rr + i) % 4;
        if (who < 0 && sv[k]) who = k;
      end
      er[who] = 1;
      e.addr = sa[who];
      e.charge = (int'($signed(sc[who])) + 512) % 512;
      q.push_back(e);
      m_rr = (who + 1) % 4;
    end
    m_vld = (who >= 0) ? 1 : (can ? 0 : m_vld);
    if (GUARD && enable) begin
      if (!m_force) begin
        if (who == 4 && any) begin
          m_cnt++;
          if (m_cnt == BMAX) m_force = 1;
        end else if ((who >= 0 && who < 4) || !any) m_cnt = 0;
      end else if ((who >= 0 && who < 4) || !any) begin
        m_force = 0; m_cnt = 0;
      end
    end
  endtask

  // Entered and left at posedge+1.
  task automatic cycle();
    bit [3:0] er; bit ei; int who;
    model(er, ei, who);
    last_who = who;
    #1;
    chk("syn_rdy", syn_dend_rdy, er);
    chk("inc_rdy", incoming_rdy, ei);
    @(posedge clk); #1;
  endtask

  task automatic refresh(input int pv, input int pi);
    for (int k = 0; k < 4; k++)
      if (last_who == k || !sv[k]) begin
        sv[k] = ($urandom % 100) < pv;
        sa[k] = 8'($urandom); sc[k] = 8'($urandom);
      end
    if (last_who == 4 || !ivld) begin
      ivld = ($urandom % 100) < pi;
      ia = 8'($urandom); ic = 8'($urandom);
    end
  endtask

  // Asynchronous reset between edges; released one edge later, also between edges.
  task automatic async_reset();
    #2 reset = 0;
    #1;
    chk("rst_dend_vld", dend_vld, 0);
    chk("rst_syn_rdy", syn_dend_rdy, 0);
    chk("rst_inc_rdy", incoming_rdy, 0);
    q.delete();
    m_rr = 0; m_cnt = 0; m_force = 0; m_vld = 0; last_who = -1;
    @(posedge clk); #1;
    reset = 1;
  endtask

  always @(negedge clk) begin
    if (reset && dend_vld && drdy) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL fire_unexpected: got addr %0h charge %0h expected none", dend_addr, dend_charge);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("fire_addr", dend_addr, e.addr);
        chk("fire_charge", dend_charge, e.charge);
      end
    end
  end

  initial begin
    int n_p1, first_p1, sa0, sc0;
    for (int k = 0; k < 4; k++) begin sa[k] = 8'(k); sc[k] = 8'(k); end
    // Reset held with every valid high
    sv = 4'hF; ivld = 1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_syn_rdy", syn_dend_rdy, 0);
    chk("rst_inc_rdy", incoming_rdy, 0);
    chk("rst_dend_vld", dend_vld, 0);
    chk("rst_dend_addr", dend_addr, 0);
    chk("rst_dend_charge", dend_charge, 0);
    // Release with only port 2 valid
    sv = 4'b0100; ivld = 0; sa[2] = 8'h12; sc[2] = 8'hFE;
    reset = 1;
    cycle();
    chk("first_vld", dend_vld, 1);
    chk("first_addr", dend_addr, 8'h12);
    chk("first_charge", dend_charge, 9'h1FE);
    sv = 4'b0;
    // Round-robin wrap from a fresh pointer
    async_reset();
    sv = 4'hF;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_order", last_who, i % 4);
    end
    // Incoming priority with zero extension
    sv = 4'b0001; sa[0] = 8'h33; sc[0] = 8'h80;
    ivld = 1; ia = 8'h44; ic = 8'hFF;
    cycle();
    chk("inc_first", last_who, 4);
    chk("inc_charge", dend_charge, 9'h0FF);
    ivld = 0;
    cycle();
    chk("port0_next", last_who, 0);
    chk("port0_charge", dend_charge, 9'h180);
    // Backpressure: outputs frozen, then no bubble
    sv = 4'hF; drdy = 0;
    sa0 = dend_addr; sc0 = dend_charge;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_vld", dend_vld, 1);
      chk("bp_addr", dend_addr, sa0);
      chk("bp_charge", dend_charge, sc0);
    end
    drdy = 1;
    cycle();
    chk("bp_no_bubble", int'(last_who >= 0), 1);
    // Starvation guard: incoming and port 1 both held valid
    sv = 4'b0; ivld = 0;
    cycle();
    sv = 4'b0010; ivld = 1;
    n_p1 = 0; first_p1 = -1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_who == 1) begin
        n_p1++;
        if (first_p1 < 0) first_p1 = i;
      end
      if (last_who == 1) begin sa[1] = 8'($urandom); sc[1] = 8'($urandom); end
      if (last_who == 4) begin ia = 8'($urandom); ic = 8'($urandom); end
    end
    chk("starve_p1_grants", n_p1, GUARD ? 2 : 0);
    chk("starve_first_p1", first_p1, GUARD ? BMAX : -1);
    // Enable low: held fire drains, nothing new granted
    enable = 0;
    cycle();
    chk("en_drain_vld", dend_vld, 0);
    chk("en_no_grant", last_who, -1);
    cycle();
    chk("en_hold_vld", dend_vld, 0);
    enable = 1;
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drdy = ($urandom % 100) < 75;
      enable = ($urandom % 100) < 90;
      refresh(50, 30);
      cycle();
    end
    // Mid-stream async reset restores rr_ptr to 0
    enable = 1; drdy = 1; sv = 4'hF; ivld = 0;
    cycle();
    async_reset();
    cycle();
    chk("post_rst_port0", last_who, 0);
    // Drain
    sv = 4'b0; ivld = 0;
    for (int i = 0; i < 3; i++) cycle();
    chk("queue_empty", q.size(), 0);
    chk("idle_end", idle, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
